// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Shared types, constants and helpers for the Keccak padding / sequencing
// front end.
//   LANE_W, NUM_LANES      : lane width and lanes per 1600-bit state
//   PAD_DOMAIN, PAD_END    : SHA-3 domain pad byte and final pad bit byte
//   state_t                : block-builder FSM states
//   lane_idx(x, y)         : state lane number for coordinate (x, y)
//   keep_bytes(word, len)  : zero every byte at or above byte index len
//   pad_mask(lane, pos, r) : OR-mask one lane needs for padding at byte pos
// -----------------------------------------------------------------------------
package keccak_pkg;

    localparam int         LANE_W     = 64;
    localparam int         NUM_LANES  = 25;
    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_END    = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD,
        EMIT
    } state_t;

    function automatic logic [4:0] lane_idx(input logic [2:0] x, input logic [2:0] y);
        return 5'(x) + 5'd5 * 5'(y);
    endfunction

    function automatic logic [LANE_W-1:0] keep_bytes(input logic [LANE_W-1:0] word,
                                                     input logic [3:0]        len);
        logic [LANE_W-1:0] keep;
        for (int i = 0; i < 8; i++) begin
            keep[8*i +: 8] = (4'(i) < len) ? 8'hFF : 8'h00;
        end
        return word & keep;
    endfunction

    // pos is a byte offset into the rate portion: pos[7:3] picks the lane,
    // pos[2:0] the byte inside it. The end bit always lands in the top byte
    // of the last rate lane, so both bytes may hit the same lane (0x86 case).
    function automatic logic [LANE_W-1:0] pad_mask(input logic [4:0] lane,
                                                   input logic [7:0] pos,
                                                   input int         rate_lanes);
        logic [LANE_W-1:0] m;
        m = '0;
        if (pos[7:3] == lane) begin
            m = m | ({56'h0, PAD_DOMAIN} << {pos[2:0], 3'b000});
        end
        if (int'(lane) == rate_lanes - 1) begin
            m = m | {PAD_END, 56'h0};
        end
        return m;
    endfunction

endpackage

// File: rtl/keccak_pad_blk_if.sv
// -----------------------------------------------------------------------------
// keccak_pad_blk_if
// Message-in / lane-out handshake bundle of keccak_pad_blk.
//   pushin/stopin/firstin/lastin/lenin/din   : message word stream (upstream)
//   pushout/stopout/firstout/lastout/dout    : lane beat stream (downstream)
// modport slave  : the padding block itself
// modport master : the environment feeding messages and draining lanes
// -----------------------------------------------------------------------------
interface keccak_pad_blk_if;
    import keccak_pkg::*;

    logic              pushin;
    logic              stopin;
    logic              firstin;
    logic              lastin;
    logic [3:0]        lenin;
    logic [LANE_W-1:0] din;

    logic              pushout;
    logic              stopout;
    logic              firstout;
    logic              lastout;
    logic [LANE_W-1:0] dout;

    modport slave (
        input  pushin, firstin, lastin, lenin, din, stopout,
        output stopin, pushout, firstout, lastout, dout
    );

    modport master (
        output pushin, firstin, lastin, lenin, din, stopout,
        input  stopin, pushout, firstout, lastout, dout
    );

endinterface

// File: rtl/keccak_lane_seq.sv
// -----------------------------------------------------------------------------
// keccak_lane_seq
// Beat counter walking the 25 state lanes in permutation write order
// (x outer, y inner). Shared with the squeeze stage.
//   clk, rst    : clock, asynchronous active-high reset
//   advance     : current beat has been consumed, step to the next
//   x, y, lane  : coordinates and lane number (x + 5y) of the current beat
//   first_beat  : current beat is beat 0
//   last_beat   : current beat is beat 24
//   done        : beat 24 is being consumed this cycle (counter wraps to 0)
// -----------------------------------------------------------------------------
module keccak_lane_seq
    import keccak_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic [4:0] lane,
    output logic       first_beat,
    output logic       last_beat,
    output logic       done
);

    // Tracking x and y directly avoids a divide-by-5 on a flat beat count.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (y == 3'd4) begin
                y <= '0;
                x <= (x == 3'd4) ? 3'd0 : x + 3'd1;
            end else begin
                y <= y + 3'd1;
            end
        end
    end

    assign lane       = lane_idx(x, y);
    assign first_beat = (x == 3'd0) && (y == 3'd0);
    assign last_beat  = (x == 3'd4) && (y == 3'd4);
    assign done       = advance && last_beat;

endmodule

// File: rtl/keccak_pad_blk.sv
// -----------------------------------------------------------------------------
// keccak_pad_blk
// Packs a little-endian 64-bit message word stream into rate lanes, applies
// SHA-3 padding (0x06 ... 0x80) and emits each 1600-bit block as 25 lane
// beats in x-outer / y-inner order. Capacity lanes are sent as zero; the
// absorb XOR is left to the permutation block.
//   RATE_LANES : rate in 64-bit lanes (17 = SHA3-256), legal 1..24
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : keccak_pad_blk_if.slave
//                in : pushin, firstin, lastin, lenin, din, stopout
//                out: stopin, pushout, firstout, lastout, dout (all registered)
// -----------------------------------------------------------------------------
module keccak_pad_blk
    import keccak_pkg::*;
#(
    parameter int RATE_LANES = 17
) (
    input  logic              clk,
    input  logic              rst,
    keccak_pad_blk_if.slave   bus
);

    localparam logic [4:0] LAST_LANE  = 5'(RATE_LANES - 1);
    localparam logic [7:0] RATE_BYTES = 8'(8 * RATE_LANES);

    state_t            state;
    logic [LANE_W-1:0] lane_buf [RATE_LANES];
    logic [4:0]        li;
    logic [7:0]        pad_pos;
    logic              final_blk;
    logic              pad_pending;

    logic              stopin_q;
    logic              pushout_q;
    logic              firstout_q;
    logic              lastout_q;
    logic [LANE_W-1:0] dout_q;

    logic              accept;
    logic              transfer;
    logic              seq_adv;
    logic [2:0]        seq_x;
    logic [2:0]        seq_y;
    logic [4:0]        seq_lane;
    logic              seq_first;
    logic              seq_last;
    logic              seq_done;

    logic [4:0]        wr_lane;
    logic [3:0]        len_eff;
    logic [LANE_W-1:0] wr_word;
    logic [7:0]        last_pos;
    logic [4:0]        next_lane;
    logic [LANE_W-1:0] next_val;
    logic [LANE_W-1:0] first_val;
    logic [LANE_W-1:0] pad_lane0;

    assign accept   = bus.pushin && !stopin_q;
    assign transfer = pushout_q && !bus.stopout;
    assign seq_adv  = (state == EMIT) && transfer;

    keccak_lane_seq u_seq (
        .clk        (clk),
        .rst        (rst),
        .advance    (seq_adv),
        .x          (seq_x),
        .y          (seq_y),
        .lane       (seq_lane),
        .first_beat (seq_first),
        .last_beat  (seq_last),
        .done       (seq_done)
    );

    // first_beat matters to the squeeze stage; here firstout is loaded on
    // entry to EMIT, so the decode is not needed.
    logic unused_seq;
    assign unused_seq = seq_first;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_val = '0;

        // A word carrying firstin always lands in lane 0, even mid-FILL.
        wr_lane  = (bus.firstin || state == IDLE) ? 5'd0 : li;
        len_eff  = !bus.lastin ? 4'd8 : (bus.lenin > 4'd8) ? 4'd8 : bus.lenin;
        wr_word  = keep_bytes(bus.din, len_eff);
        last_pos = {wr_lane, 3'b000} + {4'h0, len_eff};

        // dout is registered, so the lane for the beat after the current
        // one is looked up a cycle ahead from the sequencer position.
        if (seq_last) begin
            next_lane = 5'd0;
        end else if (seq_y == 3'd4) begin
            next_lane = 5'(seq_x) + 5'd1;
        end else begin
            next_lane = seq_lane + 5'd5;
        end
        for (int l = 0; l < RATE_LANES; l++) begin
            if (5'(l) == next_lane) begin
                next_val = lane_buf[l];
            end
        end

        // Beat 0 of a block is loaded on the same edge the buffer is
        // finished, so it is taken from the incoming word / pad mask.
        first_val = (wr_lane == 5'd0) ? wr_word : lane_buf[0];
        pad_lane0 = lane_buf[0] | pad_mask(5'd0, pad_pos, RATE_LANES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            li          <= '0;
            pad_pos     <= '0;
            final_blk   <= 1'b0;
            pad_pending <= 1'b0;
            stopin_q    <= 1'b0;
            pushout_q   <= 1'b0;
            firstout_q  <= 1'b0;
            lastout_q   <= 1'b0;
            dout_q      <= '0;
            // NOTE: the lane buffer is reset as well: lanes past the last
            // written word are relied on to read as zero in every block.
            for (int l = 0; l < RATE_LANES; l++) begin
                lane_buf[l] <= '0;
            end
        end else begin
            case (state)
                IDLE, FILL: begin
                    // In IDLE only a firstin word opens a message; anything
                    // else is accepted and dropped.
                    if (accept && (state == FILL || bus.firstin)) begin
                        if (bus.firstin) begin
                            for (int l = 0; l < RATE_LANES; l++) begin
                                lane_buf[l] <= '0;
                            end
                        end
                        for (int l = 0; l < RATE_LANES; l++) begin
                            if (5'(l) == wr_lane) begin
                                lane_buf[l] <= wr_word;
                            end
                        end
                        li <= wr_lane + 5'd1;

                        if (bus.lastin && last_pos < RATE_BYTES) begin
                            state    <= PAD;
                            pad_pos  <= last_pos;
                            stopin_q <= 1'b1;
                        end else if (bus.lastin || wr_lane == LAST_LANE) begin
                            // Full rate block. A full last lane leaves no room
                            // for padding, so a pad-only block follows.
                            state       <= EMIT;
                            final_blk   <= 1'b0;
                            pad_pending <= bus.lastin;
                            stopin_q    <= 1'b1;
                            pushout_q   <= 1'b1;
                            firstout_q  <= 1'b1;
                            lastout_q   <= 1'b0;
                            dout_q      <= first_val;
                        end else begin
                            state <= FILL;
                        end
                    end
                end

                PAD: begin
                    for (int l = 0; l < RATE_LANES; l++) begin
                        lane_buf[l] <= lane_buf[l] | pad_mask(5'(l), pad_pos, RATE_LANES);
                    end
                    state       <= EMIT;
                    final_blk   <= 1'b1;
                    pad_pending <= 1'b0;
                    pushout_q   <= 1'b1;
                    firstout_q  <= 1'b1;
                    lastout_q   <= 1'b0;
                    dout_q      <= pad_lane0;
                end

                EMIT: begin
                    if (seq_done) begin
                        pushout_q  <= 1'b0;
                        firstout_q <= 1'b0;
                        lastout_q  <= 1'b0;
                        dout_q     <= '0;
                        li         <= '0;
                        for (int l = 0; l < RATE_LANES; l++) begin
                            lane_buf[l] <= '0;
                        end
                        if (pad_pending) begin
                            state   <= PAD;
                            pad_pos <= '0;
                        end else begin
                            state    <= final_blk ? IDLE : FILL;
                            stopin_q <= 1'b0;
                        end
                    end else if (transfer) begin
                        dout_q     <= next_val;
                        firstout_q <= 1'b0;
                        lastout_q  <= final_blk && (next_lane == 5'(NUM_LANES - 1));
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.stopin   = stopin_q;
    assign bus.pushout  = pushout_q;
    assign bus.firstout = firstout_q;
    assign bus.lastout  = lastout_q;
    assign bus.dout     = dout_q;

endmodule

// File: tb/tb_keccak_pad_blk.sv
// -----------------------------------------------------------------------------
// tb_keccak_pad_blk
// Directed bench for keccak_pad_blk (RATE_LANES = 17): empty message, "abc"
// with restart and a stray word, 135-byte single block with a 3-cycle stall,
// 136-byte two-block message, and reset in the middle of a block.
// -----------------------------------------------------------------------------
module tb_keccak_pad_blk;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    keccak_pad_blk_if bus ();

    keccak_pad_blk #(.RATE_LANES(17)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_lane [25];

    localparam logic [63:0] END_LANE = 64'h8000_0000_0000_0000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'h0101_0101_0101_0101 * 64'(i + 1);
    endfunction

    function automatic int lane_of(input int b);
        return (b / 5) + 5 * (b % 5);
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < 25; i++) exp_lane[i] = '0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit first, input bit last, input logic [3:0] len,
                        input logic [63:0] data);
        int n = 0;
        bus.pushin  = 1'b1;
        bus.firstin = first;
        bus.lastin  = last;
        bus.lenin   = len;
        bus.din     = data;
        while (bus.stopin !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_bit("send_ready stopin", bus.stopin, 1'b0);
        @(negedge clk);
        bus.pushin  = 1'b0;
        bus.firstin = 1'b0;
        bus.lastin  = 1'b0;
    endtask

    // Consumes nbeats beats at negedges, optionally stalling beat stall_at.
    task automatic collect(input string tag, input bit fin, input int nbeats,
                           input int stall_at, input int stall_n);
        int n = 0;
        while (bus.pushout !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int b = 0; b < nbeats; b++) begin
            check_bit($sformatf("%s b%0d pushout", tag, b), bus.pushout, 1'b1);
            check_bit($sformatf("%s b%0d stopin", tag, b), bus.stopin, 1'b1);
            check($sformatf("%s b%0d dout", tag, b), bus.dout, exp_lane[lane_of(b)]);
            check_bit($sformatf("%s b%0d firstout", tag, b), bus.firstout, b == 0);
            check_bit($sformatf("%s b%0d lastout", tag, b), bus.lastout, fin && b == 24);
            if (b == stall_at) begin
                bus.stopout = 1'b1;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    check_bit($sformatf("%s stall%0d pushout", tag, s), bus.pushout, 1'b1);
                    check($sformatf("%s stall%0d dout", tag, s), bus.dout, exp_lane[lane_of(b)]);
                end
                bus.stopout = 1'b0;
            end
            @(negedge clk);
        end
        if (nbeats == 25) check_bit($sformatf("%s end pushout", tag), bus.pushout, 1'b0);
    endtask

    task automatic set_m135();
        clear_exp();
        for (int i = 0; i < 16; i++) exp_lane[i] = pat(i);
        exp_lane[16] = 64'h8611_1111_1111_1111;
    endtask

    task automatic set_abc();
        clear_exp();
        exp_lane[0]  = 64'h0000_0000_0663_6261;
        exp_lane[16] = END_LANE;
    endtask

    initial begin
        rst         = 1'b1;
        bus.pushin  = 1'b0;
        bus.firstin = 1'b0;
        bus.lastin  = 1'b0;
        bus.lenin   = 4'd0;
        bus.din     = '0;
        bus.stopout = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("rst pushout", bus.pushout, 1'b0);
        check_bit("rst stopin", bus.stopin, 1'b0);
        check_bit("rst firstout", bus.firstout, 1'b0);
        check_bit("rst lastout", bus.lastout, 1'b0);
        check("rst dout", bus.dout, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Empty message: garbage data must be masked away entirely.
        clear_exp();
        exp_lane[0]  = 64'h0000_0000_0000_0006;
        exp_lane[16] = END_LANE;
        send(1'b1, 1'b1, 4'd0, 64'hDEAD_BEEF_0123_4567);
        check_bit("empty pad pushout", bus.pushout, 1'b0);
        check_bit("empty pad stopin", bus.stopin, 1'b1);
        @(negedge clk);
        check_bit("empty latency pushout", bus.pushout, 1'b1);
        collect("empty", 1'b1, 25, -1, 0);
        check_bit("empty idle stopin", bus.stopin, 1'b0);

        // Stray last word without firstin in IDLE: dropped, no block.
        send(1'b0, 1'b1, 4'd2, pat(5));
        @(negedge clk);
        check_bit("stray pushout a", bus.pushout, 1'b0);
        @(negedge clk);
        check_bit("stray pushout b", bus.pushout, 1'b0);

        // Partial message, then "abc" restarts it; old lanes must vanish.
        send(1'b1, 1'b0, 4'd8, pat(0));
        send(1'b0, 1'b0, 4'd8, pat(1));
        send(1'b0, 1'b0, 4'd8, pat(2));
        set_abc();
        send(1'b1, 1'b1, 4'd3, 64'hFFFF_FFFF_FF63_6261);
        check_bit("abc pad pushout", bus.pushout, 1'b0);
        @(negedge clk);
        collect("abc", 1'b1, 25, -1, 0);

        // 135 bytes: pad bytes coincide (0x86), stall of 3 cycles at beat 7.
        set_m135();
        for (int i = 0; i < 16; i++) send(i == 0, 1'b0, 4'd8, pat(i));
        send(1'b0, 1'b1, 4'd7, pat(16));
        check_bit("m135 pad pushout", bus.pushout, 1'b0);
        @(negedge clk);
        collect("m135", 1'b1, 25, 7, 3);

        // 136 bytes: full data block, then a pad-only final block.
        clear_exp();
        for (int i = 0; i < 17; i++) exp_lane[i] = pat(i);
        for (int i = 0; i < 16; i++) send(i == 0, 1'b0, 4'd8, pat(i));
        send(1'b0, 1'b1, 4'd8, pat(16));
        check_bit("m136 latency pushout", bus.pushout, 1'b1);
        check_bit("m136 latency stopin", bus.stopin, 1'b1);
        collect("m136a", 1'b0, 25, -1, 0);
        check_bit("m136 gap stopin", bus.stopin, 1'b1);
        clear_exp();
        exp_lane[0]  = 64'h0000_0000_0000_0006;
        exp_lane[16] = END_LANE;
        collect("m136b", 1'b1, 25, -1, 0);
        check_bit("m136 idle stopin", bus.stopin, 1'b0);

        // Reset while beat 12 is on the bus, then a clean "abc".
        set_m135();
        for (int i = 0; i < 16; i++) send(i == 0, 1'b0, 4'd8, pat(i));
        send(1'b0, 1'b1, 4'd7, pat(16));
        @(negedge clk);
        collect("rst135", 1'b1, 12, -1, 0);
        rst = 1'b1;
        #1;
        check_bit("midrst pushout", bus.pushout, 1'b0);
        check_bit("midrst stopin", bus.stopin, 1'b0);
        check_bit("midrst firstout", bus.firstout, 1'b0);
        check("midrst dout", bus.dout, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_abc();
        send(1'b1, 1'b1, 4'd3, 64'h0000_0000_0063_6261);
        check_bit("abc2 pad pushout", bus.pushout, 1'b0);
        @(negedge clk);
        collect("abc2", 1'b1, 25, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
